// File: rtl/dsp19x2_addshift_result_checker_if.sv
// ----------------------------------------------------------------------------
// dsp19x2_addshift_result_checker_if
//   Bundles the stimulus/result bus between a DSP19x2 stimulus source and the
//   on-chip result checker.
//   master : drives stimulus (start, end_of_test, stim_valid, a, b, acc_fir)
//            and the DUT result z_out; observes the checker status.
//   slave  : the checker itself.
//   Optional first-fail capture signals exist only when
//   DSP19X2_CHECKER_FIRST_FAIL_EN is defined.
// ----------------------------------------------------------------------------
interface dsp19x2_addshift_result_checker_if #(
    parameter int unsigned CNT_W = 16
);
    logic             start;
    logic             end_of_test;
    logic             stim_valid;
    logic [19:0]      a;
    logic [17:0]      b;
    logic [4:0]       acc_fir;
    logic [37:0]      z_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] vec_cnt;
    logic [CNT_W-1:0] mismatch_cnt;
    logic [37:0]      exp_out;
`ifdef DSP19X2_CHECKER_FIRST_FAIL_EN
    logic             fail_seen;
    logic [CNT_W-1:0] fail_idx;
    logic [37:0]      fail_exp;
    logic [37:0]      fail_act;

    modport master (
        output start, end_of_test, stim_valid, a, b, acc_fir, z_out,
        input  busy, done, pass, vec_cnt, mismatch_cnt, exp_out,
        input  fail_seen, fail_idx, fail_exp, fail_act
    );
    modport slave (
        input  start, end_of_test, stim_valid, a, b, acc_fir, z_out,
        output busy, done, pass, vec_cnt, mismatch_cnt, exp_out,
        output fail_seen, fail_idx, fail_exp, fail_act
    );
`else
    modport master (
        output start, end_of_test, stim_valid, a, b, acc_fir, z_out,
        input  busy, done, pass, vec_cnt, mismatch_cnt, exp_out
    );
    modport slave (
        input  start, end_of_test, stim_valid, a, b, acc_fir, z_out,
        output busy, done, pass, vec_cnt, mismatch_cnt, exp_out
    );
`endif
endinterface

// File: rtl/dsp19x2_addshift_result_checker.sv
// ----------------------------------------------------------------------------
// dsp19x2_addshift_result_checker
//   On-chip judge for a DSP19x2 in "shifted A plus multiplier" mode. Computes
//   the golden dual-lane result from the shared stimulus, delays it by LATENCY
//   cycles, compares against z_out and keeps saturating vector / mismatch
//   counters plus a run state machine (IDLE, RUN, DRAIN, DONE).
//
//   Parameters : LATENCY (1..8), COEFF0, COEFF1, CNT_W
//   Ports      : clk_i   - clock, rising edge
//                reset_i - synchronous active-high reset
//                bus     - checker side of the stimulus/result interface
//   Optional   : define DSP19X2_CHECKER_FIRST_FAIL_EN to capture index,
//                expected and actual value of the first mismatch of a run.
// ----------------------------------------------------------------------------
module dsp19x2_addshift_result_checker #(
    parameter int unsigned LATENCY = 1,
    parameter logic [9:0]  COEFF0  = 10'h000,
    parameter logic [9:0]  COEFF1  = 10'h001,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    dsp19x2_addshift_result_checker_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

    // Marks the output stage of the delay line.
    localparam logic [LATENCY-1:0] LAST_STG = LATENCY'(1) << (LATENCY - 1);

    state_e state_q, state_d;
    logic   clr, push;

    logic [LATENCY-1:0]       vld_q;
    logic [LATENCY-1:0][37:0] exp_pipe_q;
    logic [37:0]              exp_d;
    logic                     cmp, miss;

    logic [CNT_W-1:0] vec_cnt_q, mis_cnt_q;
    logic [37:0]      exp_out_q;

    // One lane: (A << sh) + coeff*B, only the low 19 bits survive, so a shift
    // of 19 or more leaves nothing of the A term.
    function automatic logic [18:0] lane_f(input logic [9:0] a_l,
                                           input logic [8:0] b_l,
                                           input logic [4:0] sh,
                                           input logic [9:0] coeff);
        logic [31:0] a_sh, prod;
        a_sh = {22'd0, a_l} << sh;
        prod = {22'd0, coeff} * {23'd0, b_l};
        return 19'(a_sh + prod);
    endfunction

    assign exp_d = {lane_f(bus.a[19:10], bus.b[17:9], bus.acc_fir, COEFF1),
                    lane_f(bus.a[9:0],   bus.b[8:0],  bus.acc_fir, COEFF0)};

    // ---------------- run control ----------------
    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        push    = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    clr     = 1'b1;
                end
            end
            S_RUN: begin
                push = bus.stim_valid;
                if (bus.end_of_test) state_d = S_DRAIN;
            end
            // Leave as soon as the only valid stage left is the one retiring
            // now, so done rises together with the last compare result.
            S_DRAIN: begin
                if ((vld_q & ~LAST_STG) == '0) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- expected-value delay line ----------------
    always_ff @(posedge clk_i) begin
        if (reset_i || clr) begin
            vld_q      <= '0;
            exp_pipe_q <= '0;
        end else begin
            vld_q[0]      <= push;
            exp_pipe_q[0] <= exp_d;
            for (int i = 1; i < int'(LATENCY); i++) begin
                vld_q[i]      <= vld_q[i-1];
                exp_pipe_q[i] <= exp_pipe_q[i-1];
            end
        end
    end

    assign cmp  = vld_q[LATENCY-1];
    assign miss = bus.z_out != exp_pipe_q[LATENCY-1];

    // ---------------- compare / counters ----------------
    always_ff @(posedge clk_i) begin
        if (reset_i || clr) begin
            vec_cnt_q <= '0;
            mis_cnt_q <= '0;
            exp_out_q <= '0;
        end else if (cmp) begin
            exp_out_q <= exp_pipe_q[LATENCY-1];
            if (vec_cnt_q != '1)         vec_cnt_q <= vec_cnt_q + CNT_W'(1);
            if (miss && mis_cnt_q != '1) mis_cnt_q <= mis_cnt_q + CNT_W'(1);
        end
    end

`ifdef DSP19X2_CHECKER_FIRST_FAIL_EN
    logic             fail_seen_q;
    logic [CNT_W-1:0] fail_idx_q;
    logic [37:0]      fail_exp_q, fail_act_q;

    always_ff @(posedge clk_i) begin
        if (reset_i || clr) begin
            fail_seen_q <= 1'b0;
            fail_idx_q  <= '0;
            fail_exp_q  <= '0;
            fail_act_q  <= '0;
        end else if (cmp && miss && !fail_seen_q) begin
            fail_seen_q <= 1'b1;
            fail_idx_q  <= vec_cnt_q;   // index of this vector within the run
            fail_exp_q  <= exp_pipe_q[LATENCY-1];
            fail_act_q  <= bus.z_out;
        end
    end

    assign bus.fail_seen = fail_seen_q;
    assign bus.fail_idx  = fail_idx_q;
    assign bus.fail_exp  = fail_exp_q;
    assign bus.fail_act  = fail_act_q;
`endif

    assign bus.busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign bus.done         = (state_q == S_DONE);
    assign bus.pass         = (state_q == S_DONE) && (mis_cnt_q == '0);
    assign bus.vec_cnt      = vec_cnt_q;
    assign bus.mismatch_cnt = mis_cnt_q;
    assign bus.exp_out      = exp_out_q;
endmodule

// File: tb/tb_dsp19x2_addshift_result_checker.sv
`timescale 1ns/1ps
module tb_dsp19x2_addshift_result_checker;
    // Three checkers share one stimulus stream; each has its own latency,
    // coefficients and counter width and gets its own aligned z_out.
    localparam int L0 = 1, L1 = 3, L2 = 2;
    localparam int W0 = 16, W1 = 16, W2 = 4;
    localparam logic [9:0] C00 = 10'h000, C01 = 10'h001;
    localparam logic [9:0] C10 = 10'h3a5, C11 = 10'h2c7;
    localparam logic [9:0] C20 = 10'h155, C21 = 10'h0ff;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, st, eot, sv;
    logic [19:0] a;
    logic [17:0] b;
    logic [4:0]  sh;
    logic [37:0] zd [3];

    dsp19x2_addshift_result_checker_if #(.CNT_W(W0)) if0();
    dsp19x2_addshift_result_checker_if #(.CNT_W(W1)) if1();
    dsp19x2_addshift_result_checker_if #(.CNT_W(W2)) if2();

    assign if0.start = st; assign if0.end_of_test = eot; assign if0.stim_valid = sv;
    assign if0.a = a; assign if0.b = b; assign if0.acc_fir = sh; assign if0.z_out = zd[0];
    assign if1.start = st; assign if1.end_of_test = eot; assign if1.stim_valid = sv;
    assign if1.a = a; assign if1.b = b; assign if1.acc_fir = sh; assign if1.z_out = zd[1];
    assign if2.start = st; assign if2.end_of_test = eot; assign if2.stim_valid = sv;
    assign if2.a = a; assign if2.b = b; assign if2.acc_fir = sh; assign if2.z_out = zd[2];

    dsp19x2_addshift_result_checker #(.LATENCY(L0), .COEFF0(C00), .COEFF1(C01), .CNT_W(W0))
        u0 (.clk_i(clk), .reset_i(reset), .bus(if0));
    dsp19x2_addshift_result_checker #(.LATENCY(L1), .COEFF0(C10), .COEFF1(C11), .CNT_W(W1))
        u1 (.clk_i(clk), .reset_i(reset), .bus(if1));
    dsp19x2_addshift_result_checker #(.LATENCY(L2), .COEFF0(C20), .COEFF1(C21), .CNT_W(W2))
        u2 (.clk_i(clk), .reset_i(reset), .bus(if2));

    logic [15:0] vc [3], mc [3];
    logic [37:0] eo [3];
    logic        bsy [3], dn [3], ps [3];
    assign vc[0] = if0.vec_cnt; assign vc[1] = if1.vec_cnt; assign vc[2] = {12'd0, if2.vec_cnt};
    assign mc[0] = if0.mismatch_cnt; assign mc[1] = if1.mismatch_cnt;
    assign mc[2] = {12'd0, if2.mismatch_cnt};
    assign eo[0] = if0.exp_out; assign eo[1] = if1.exp_out; assign eo[2] = if2.exp_out;
    assign bsy[0] = if0.busy; assign bsy[1] = if1.busy; assign bsy[2] = if2.busy;
    assign dn[0] = if0.done; assign dn[1] = if1.done; assign dn[2] = if2.done;
    assign ps[0] = if0.pass; assign ps[1] = if1.pass; assign ps[2] = if2.pass;

    // ---------------- reference model state ----------------
    int          lat [3], cw [3], cf0 [3], cf1 [3];
    int          total = 0, bad = 0, edge_n = 0;
    bit          mrun;
    int          mvec [3], mmis [3], mfidx [3];
    logic [37:0] mexp [3];
    logic [37:0] flip [3];
    logic [37:0] zs [int];      // key = edge*4 + dut: z value the DUT must see at that edge

    function automatic logic [37:0] gold(int k, logic [19:0] av, logic [17:0] bv, logic [4:0] s);
        longint m = 524288, l0, l1;
        l0 = ((longint'(av[9:0])  << s) + longint'(cf0[k]) * longint'(bv[8:0]))  % m;
        l1 = ((longint'(av[19:10]) << s) + longint'(cf1[k]) * longint'(bv[17:9])) % m;
        return {l1[18:0], l0[18:0]};
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        #1;
        for (int k = 0; k < 3; k++)
            zd[k] = zs.exists((edge_n + 1) * 4 + k) ? zs[(edge_n + 1) * 4 + k] : 38'h0;
    endtask

    // Apply one cycle of stimulus (sampled at the next edge) and update the model.
    task automatic drive(bit s_st, bit s_eot, bit s_sv, logic [19:0] av, logic [17:0] bv,
                         logic [4:0] s);
        logic [37:0] g;
        st = s_st; eot = s_eot; sv = s_sv; a = av; b = bv; sh = s;
        if (mrun && s_sv) begin
            for (int k = 0; k < 3; k++) begin
                g = gold(k, av, bv, s);
                zs[(edge_n + 1 + lat[k]) * 4 + k] = g ^ flip[k];
                if (flip[k] != 0) begin
                    if (mmis[k] == 0) mfidx[k] = mvec[k];
                    mmis[k]++;
                end
                mvec[k]++;
                mexp[k] = g;
            end
        end
        if (mrun && s_eot) mrun = 1'b0;
        else if (!mrun && s_st) begin
            mrun = 1'b1;
            for (int k = 0; k < 3; k++) begin mvec[k] = 0; mmis[k] = 0; mexp[k] = '0; end
        end
        tick();
    endtask

    task automatic drive_rand(bit s_st, bit s_eot);
        drive(s_st, s_eot, 1'b1, 20'($urandom), 18'($urandom), 5'($urandom));
    endtask

    task automatic do_reset();
        reset = 1'b1; st = 1'b0; eot = 1'b0;
        tick(); tick();
        reset = 1'b0;
        mrun = 1'b0;
        zs.delete();
        for (int k = 0; k < 3; k++) begin mvec[k] = 0; mmis[k] = 0; mexp[k] = '0; end
    endtask

    task automatic check_reset(string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s vec%0d", tag, k), 64'(vc[k]), 0);
            chk($sformatf("%s mis%0d", tag, k), 64'(mc[k]), 0);
            chk($sformatf("%s exp%0d", tag, k), 64'(eo[k]), 0);
            chk($sformatf("%s busy%0d", tag, k), 64'(bsy[k]), 0);
            chk($sformatf("%s done%0d", tag, k), 64'(dn[k]), 0);
            chk($sformatf("%s pass%0d", tag, k), 64'(ps[k]), 0);
        end
    endtask

    // Bounded wait; stimulus with stim_valid=1 keeps flowing and must be ignored.
    task automatic wait_done();
        for (int t = 0; t < 20; t++) begin
            if (dn[0] && dn[1] && dn[2]) return;
            drive_rand(1'b0, 1'b0);
        end
    endtask

    task automatic check_all(string tag);
        int sat;
        for (int k = 0; k < 3; k++) begin
            sat = (1 << cw[k]) - 1;
            chk($sformatf("%s done%0d", tag, k), 64'(dn[k]), 1);
            chk($sformatf("%s busy%0d", tag, k), 64'(bsy[k]), 0);
            chk($sformatf("%s vec%0d", tag, k), 64'(vc[k]), 64'(mvec[k] > sat ? sat : mvec[k]));
            chk($sformatf("%s mis%0d", tag, k), 64'(mc[k]), 64'(mmis[k] > sat ? sat : mmis[k]));
            chk($sformatf("%s exp%0d", tag, k), 64'(eo[k]), 64'(mexp[k]));
            chk($sformatf("%s pass%0d", tag, k), 64'(ps[k]), 64'(mmis[k] == 0));
        end
    endtask

    typedef struct {
        logic [19:0] a;
        logic [17:0] b;
        logic [4:0]  sh;
        logic [37:0] exp;   // expected exp_out for the checker with COEFF0=0, COEFF1=1
    } vec_t;
    vec_t tbl [6];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pushed;
        lat = '{L0, L1, L2}; cw = '{W0, W1, W2};
        cf0 = '{int'(C00), int'(C10), int'(C20)};
        cf1 = '{int'(C01), int'(C11), int'(C21)};
        flip = '{38'h0, 38'h0, 38'h0};
        st = 0; eot = 0; sv = 0; a = '0; b = '0; sh = '0;
        zd = '{38'h0, 38'h0, 38'h0};

        tbl[0] = '{20'd255,    18'd1,       5'd2,  38'd1020};
        tbl[1] = '{20'hfffff,  18'h3ffff,   5'd2,  {19'd4603, 19'd4092}};
        tbl[2] = '{20'hfffff,  18'h3ffff,   5'd19, {19'd511, 19'd0}};
        tbl[3] = '{20'd3,      18'd0,       5'd18, {19'd0, 19'h40000}};
        tbl[4] = '{20'h00400,  18'd0,       5'd31, 38'd0};
        tbl[5] = '{20'h00001,  18'h00200,   5'd0,  {19'd1, 19'd1}};

        do_reset();
        check_reset("reset");

        // Single-vector runs; end_of_test arrives with the vector itself.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
            drive(1'b0, 1'b1, 1'b1, tbl[i].a, tbl[i].b, tbl[i].sh);
            eot = 1'b0;
            for (int j = 1; j <= 4; j++) begin
                tick();
                for (int k = 0; k < 3; k++)
                    chk($sformatf("tbl%0d done%0d +%0d", i, k, j), 64'(dn[k]), 64'(j >= lat[k]));
            end
            chk($sformatf("tbl%0d exp_out", i), 64'(eo[0]), 64'(tbl[i].exp));
            check_all($sformatf("tbl%0d", i));
        end

        // 600 random vectors with gaps, one corrupted result at index 37
        // (plus a lane-1 corruption at index 400 for checker 1).
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
        pushed = 0;
        while (pushed < 600) begin
            if ($urandom_range(9) == 0) begin
                drive(1'b0, 1'b0, 1'b0, 20'($urandom), 18'($urandom), 5'($urandom));
            end else begin
                flip[0] = (pushed == 37) ? 38'h1 : 38'h0;
                flip[1] = (pushed == 37) ? 38'h1 : (pushed == 400) ? 38'h20_0000_0000 : 38'h0;
                flip[2] = (pushed == 37) ? 38'h1 : 38'h0;
                drive_rand(pushed == 100, pushed == 599);
                pushed++;
            end
        end
        flip = '{38'h0, 38'h0, 38'h0};
        wait_done();
        check_all("rand");
        chk("rand vec_cnt600", 64'(vc[0]), 600);
        chk("rand mis1", 64'(mc[0]), 1);
        chk("rand pass0", 64'(ps[0]), 0);
`ifdef DSP19X2_CHECKER_FIRST_FAIL_EN
        chk("rand fail_idx0", 64'(if0.fail_idx), 37);
        chk("rand fail_seen0", 64'(if0.fail_seen), 1);
        chk("rand fail_idx2", 64'(if2.fail_idx), 15);
`endif

        // Saturation: 20 corrupted vectors back to back.
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
        flip = '{38'h20, 38'h20, 38'h20};
        for (int i = 0; i < 20; i++) drive_rand(1'b0, i == 19);
        flip = '{38'h0, 38'h0, 38'h0};
        wait_done();
        check_all("sat");
        chk("sat vec15", 64'(vc[2]), 15);
        chk("sat mis15", 64'(mc[2]), 15);
        chk("sat pass0", 64'(ps[2]), 0);

        // Reset in the middle of a run with vectors in flight.
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
        for (int i = 0; i < 5; i++) drive_rand(1'b0, 1'b0);
        do_reset();
        check_reset("midrst");
        for (int i = 0; i < 4; i++) drive_rand(1'b0, 1'b0);
        check_reset("postrst");

        // A clean run still works afterwards.
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
        for (int i = 0; i < 8; i++) drive_rand(1'b0, i == 7);
        wait_done();
        check_all("after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
